// File: rtl/pattern_pkg.sv
// Shared constants and types for the LED pattern memory write/playback path.
package pattern_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DEPTH  = 2 ** ADDR_W;
   localparam int unsigned CNT_W  = ADDR_W + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      CLEAR = 2'd2,
      FULL  = 2'd3
   } wr_state_e;

   // One write beat towards the pattern RAM.
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_beat_t;

endpackage

// File: rtl/pattern_writer_if.sv
// Switch/button inputs and pattern RAM write port of the pattern writer.
interface pattern_writer_if;
   import pattern_pkg::*;

   logic [DATA_W-1:0] swData;
   logic              loadBtn;
   logic              clearBtn;
   logic [ADDR_W-1:0] addrWr;
   logic [DATA_W-1:0] dataWr;
   logic              wrEn;
   logic [CNT_W-1:0]  wrCount;
   logic              full;
   logic              busy;

   // Writer side: owns the RAM write port.
   modport master (
      input  swData, loadBtn, clearBtn,
      output addrWr, dataWr, wrEn, wrCount, full, busy
   );

   // Board/RAM side.
   modport slave (
      output swData, loadBtn, clearBtn,
      input  addrWr, dataWr, wrEn, wrCount, full, busy
   );

endinterface

// File: rtl/pattern_writer_btn_debounce.sv
// Button conditioning: 2-FF synchronizer, debounce filter, rising-edge pulse.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 120_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic pulse_o
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q, sync2_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pulse_q, pulse_d;

   // Accept a new level only after it has disagreed for DEBOUNCE_CYCLES clocks in a row.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      pulse_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
            pulse_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Synchronizer, filter state and pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/pattern_writer.sv
// Write-port master of the LED pattern RAM: sequential loads and full clears.
module pattern_writer
   import pattern_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 120_000
) (
   input logic             clk,
   input logic             rst,
   pattern_writer_if.master bus
);

   logic load_pulse, clear_pulse;

   wr_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              wr_en_q, wr_en_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              full_q, full_d;
   logic              busy_q, busy_d;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (bus.loadBtn),
      .pulse_o(load_pulse)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
      .clk    (clk),
      .rst    (rst),
      .btn_i  (bus.clearBtn),
      .pulse_o(clear_pulse)
   );

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         wr_en_q <= 1'b0;
         count_q <= '0;
         full_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wr_en_q <= wr_en_d;
         count_q <= count_d;
         full_q  <= full_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state logic; clear has priority over load.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (clear_pulse)      state_d = CLEAR;
            else if (load_pulse)  state_d = WRITE;
         end
         WRITE: begin
            if (count_q == CNT_W'(DEPTH - 1)) state_d = FULL;
            else                              state_d = IDLE;
         end
         CLEAR: begin
            if (addr_q == ADDR_W'(DEPTH - 1)) state_d = IDLE;
         end
         FULL: begin
            if (clear_pulse) state_d = CLEAR;
         end
         default: state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs.
   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      wr_en_d = 1'b0;
      count_d = count_q;
      full_d  = full_q;
      busy_d  = 1'b0;
      case (state_q)
         IDLE, FULL: begin
            if (clear_pulse) begin
               addr_d  = '0;
               data_d  = '0;
               wr_en_d = 1'b1;
               busy_d  = 1'b1;
            end else if (load_pulse && state_q == IDLE) begin
               addr_d  = count_q[ADDR_W-1:0];
               data_d  = bus.swData;
               wr_en_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         WRITE: begin
            if (count_q != CNT_W'(DEPTH)) count_d = count_q + CNT_W'(1);
            full_d = (count_q == CNT_W'(DEPTH - 1));
         end
         CLEAR: begin
            if (addr_q == ADDR_W'(DEPTH - 1)) begin
               addr_d  = '0;
               count_d = '0;
               full_d  = 1'b0;
            end else begin
               addr_d  = addr_q + ADDR_W'(1);
               data_d  = '0;
               wr_en_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.addrWr  = addr_q;
   assign bus.dataWr  = data_q;
   assign bus.wrEn    = wr_en_q;
   assign bus.wrCount = count_q;
   assign bus.full    = full_q;
   assign bus.busy    = busy_q;

endmodule

// File: tb/tb_pattern_writer.sv
// Scoreboard bench for pattern_writer with a short debounce window.
module tb_pattern_writer;
   import pattern_pkg::*;

   localparam int unsigned DEB = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pattern_writer_if bus();

   pattern_writer #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int       n_checks = 0;
   int       n_fail   = 0;
   int       exp_cnt  = 0;
   wr_beat_t sb[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Every observed write must match the oldest expected beat.
   wr_beat_t mon_e;
   always @(negedge clk) begin
      if (rst === 1'b0 && bus.wrEn === 1'b1) begin
         check_eq("wr_expected", {31'b0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check_eq("wr_addr", 32'(bus.addrWr), 32'(mon_e.addr));
            check_eq("wr_data", 32'(bus.dataWr), 32'(mon_e.data));
            check_eq("wr_busy", 32'(bus.busy), 32'd1);
         end
      end
   end

   task automatic push_clear();
      wr_beat_t b;
      for (int k = 0; k < int'(DEPTH); k++) begin
         b.addr = ADDR_W'(k);
         b.data = '0;
         sb.push_back(b);
      end
      exp_cnt = 0;
   endtask

   task automatic wait_wr();
      bit ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (bus.wrEn === 1'b1) ok = 1'b1;
      end
      check_eq("wr_timeout", {31'b0, ok}, 32'd1);
   endtask

   // Called on the first clear write cycle; checks 16 back-to-back beats.
   task automatic check_burst();
      for (int k = 0; k < int'(DEPTH); k++) begin
         check_eq("clr_wren", 32'(bus.wrEn), 32'd1);
         check_eq("clr_busy", 32'(bus.busy), 32'd1);
         check_eq("clr_addr", 32'(bus.addrWr), 32'(k));
         @(negedge clk);
      end
      check_eq("clr_end_wren", 32'(bus.wrEn), 32'd0);
   endtask

   task automatic do_clear();
      push_clear();
      @(negedge clk);
      bus.clearBtn = 1'b1;
      wait_wr();
      check_burst();
      bus.clearBtn = 1'b0;
      repeat (20) @(negedge clk);
      check_eq("clr_count", 32'(bus.wrCount), 32'd0);
      check_eq("clr_full", 32'(bus.full), 32'd0);
   endtask

   task automatic load_write(input logic [DATA_W-1:0] d);
      wr_beat_t b;
      if (exp_cnt < int'(DEPTH)) begin
         b.addr = ADDR_W'(exp_cnt);
         b.data = d;
         sb.push_back(b);
         exp_cnt++;
      end
      @(negedge clk);
      bus.swData  = d;
      bus.loadBtn = 1'b1;
      repeat (20) @(negedge clk);
      bus.loadBtn = 1'b0;
      repeat (20) @(negedge clk);
   endtask

   initial begin
      rst          = 1'b1;
      bus.swData   = '0;
      bus.loadBtn  = 1'b0;
      bus.clearBtn = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Quiet after reset.
      repeat (50) @(negedge clk);
      check_eq("rst_addr", 32'(bus.addrWr), 32'd0);
      check_eq("rst_count", 32'(bus.wrCount), 32'd0);
      check_eq("rst_full", 32'(bus.full), 32'd0);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);

      // Bouncy press yields one write.
      begin
         wr_beat_t b;
         b.addr = '0;
         b.data = 16'hA5A5;
         sb.push_back(b);
         exp_cnt = 1;
      end
      bus.swData = 16'hA5A5;
      bus.loadBtn = 1'b1; repeat (2) @(negedge clk);
      bus.loadBtn = 1'b0; repeat (2) @(negedge clk);
      bus.loadBtn = 1'b1; repeat (22) @(negedge clk);
      bus.loadBtn = 1'b0; repeat (20) @(negedge clk);
      check_eq("bounce_count", 32'(bus.wrCount), 32'd1);
      check_eq("bounce_data", 32'(bus.dataWr), 32'hA5A5);
      check_eq("bounce_addr", 32'(bus.addrWr), 32'd0);
      check_eq("bounce_sb", 32'(sb.size()), 32'd0);

      // Fill all 16 entries, then a 17th press must be blocked.
      do_clear();
      for (int i = 0; i < int'(DEPTH); i++) begin
         load_write(DATA_W'(16'h0001 << i));
         if (i == int'(DEPTH) - 2) check_eq("full_early", 32'(bus.full), 32'd0);
      end
      check_eq("fill_full", 32'(bus.full), 32'd1);
      check_eq("fill_count", 32'(bus.wrCount), 32'd16);
      check_eq("fill_busy", 32'(bus.busy), 32'd0);
      load_write(16'hFFFF);
      check_eq("over_count", 32'(bus.wrCount), 32'd16);
      check_eq("over_full", 32'(bus.full), 32'd1);
      check_eq("over_sb", 32'(sb.size()), 32'd0);

      // Simultaneous load+clear with three words loaded: clear wins.
      do_clear();
      for (int i = 0; i < 3; i++) load_write(DATA_W'(16'h1100 + i));
      check_eq("pre_count", 32'(bus.wrCount), 32'd3);
      push_clear();
      @(negedge clk);
      bus.swData   = 16'h7777;
      bus.loadBtn  = 1'b1;
      bus.clearBtn = 1'b1;
      wait_wr();
      check_burst();
      bus.loadBtn  = 1'b0;
      bus.clearBtn = 1'b0;
      repeat (20) @(negedge clk);
      check_eq("both_count", 32'(bus.wrCount), 32'd0);
      check_eq("both_sb", 32'(sb.size()), 32'd0);

      // Reset on the 7th clear beat.
      push_clear();
      @(negedge clk);
      bus.clearBtn = 1'b1;
      wait_wr();
      repeat (6) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check_eq("rstmid_wren", 32'(bus.wrEn), 32'd0);
      check_eq("rstmid_busy", 32'(bus.busy), 32'd0);
      check_eq("rstmid_addr", 32'(bus.addrWr), 32'd0);
      check_eq("rstmid_count", 32'(bus.wrCount), 32'd0);
      sb.delete();
      bus.clearBtn = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b0;
      exp_cnt = 0;
      load_write(16'hBEEF);
      check_eq("post_rst_count", 32'(bus.wrCount), 32'd1);
      check_eq("post_rst_sb", 32'(sb.size()), 32'd0);

      // Load pressed during a clear is dropped.
      bus.swData = 16'h1234;
      push_clear();
      @(negedge clk);
      bus.clearBtn = 1'b1;
      wait_wr();
      bus.loadBtn = 1'b1;
      check_burst();
      repeat (10) @(negedge clk);
      bus.loadBtn  = 1'b0;
      bus.clearBtn = 1'b0;
      repeat (30) @(negedge clk);
      check_eq("ign_count", 32'(bus.wrCount), 32'd0);
      check_eq("ign_data", 32'(bus.dataWr), 32'd0);
      check_eq("ign_sb", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
